// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract,
// both on operand magnitudes. Signs are applied in a single FIX cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  hi_we,
  input  logic                  lo_we,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;

  logic [1:0]     op_q;
  logic           neg_q;    // negate product / quotient
  logic           neg_r;    // negate remainder (dividend sign)
  logic           dz_q;     // divide by zero detected at launch
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] acc;      // multiply accumulator: {partial, multiplier bits}
  logic [W:0]     rem;      // partial remainder with guard bit
  logic [W-1:0]   quo;      // dividend shifting out, quotient shifting in
  logic [CW-1:0]  cnt;

  // Operand magnitudes and sign flags at launch; op[0]=0 selects signed ops
  logic         sgn_ok, a_neg, b_neg;
  logic [W-1:0] a_abs, b_abs;
  assign sgn_ok = ~op[0];
  assign a_neg  = sgn_ok & rs_data[W-1];
  assign b_neg  = sgn_ok & rt_data[W-1];
  assign a_abs  = a_neg ? -rs_data : rs_data;
  assign b_abs  = b_neg ? -rt_data : rt_data;

  // One iteration of each algorithm
  logic [W:0] mul_sum, div_sh, div_diff;
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign div_sh   = {rem[W-1:0], quo[W-1]};
  assign div_diff = div_sh - {1'b0, b_mag};

  // Sign fix-up of the finished magnitudes
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_fix, r_fix;
  assign prod  = neg_q ? -acc : acc;
  assign q_fix = dz_q ? '1 : (neg_q ? -quo : quo);
  assign r_fix = neg_r ? -rem[W-1:0] : rem[W-1:0];

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: fixed-length run of W iterations then one fix-up cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, HI/LO and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; neg_q <= 1'b0; neg_r <= 1'b0; dz_q <= 1'b0;
      a_mag <= '0; b_mag <= '0; acc <= '0; rem <= '0; quo <= '0;
      cnt <= '0; hi <= '0; lo <= '0; done <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            dz_q     <= op[1] & (rt_data == '0);
            a_mag    <= a_abs;
            b_mag    <= b_abs;
            acc      <= {{W{1'b0}}, b_abs};
            rem      <= '0;
            quo      <= a_abs;
            cnt      <= CW'(W-1);
            div_zero <= 1'b0;
          end else begin
            if (hi_we) hi <= rs_data;
            if (lo_we) lo <= rs_data;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op_q[1]) begin
            if (!div_diff[W]) begin
              rem <= div_diff;
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= div_sh;
              quo <= {quo[W-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (op_q[1]) begin
            hi       <= r_fix;
            lo       <= q_fix;
            div_zero <= dz_q;
          end else begin
            hi <= prod[2*W-1:W];
            lo <= prod[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
